// File: rtl/pll_reset_sequencer.sv
// Lock supervisor beside a PLL/MMCM: drives RST/PWRDWN, qualifies LOCKED, retries on
// timeout or lock loss, and releases CLKOUT_NUM domain resets one after another.

module pll_rst_lane #(
  parameter int IDX = 0,
  parameter int GAP = 1,
  parameter int CW  = 8
) (
  input  logic          clk_in,
  input  logic          reset_in_n,
  input  logic [CW-1:0] cnt,
  input  logic          rel_en,
  input  logic          hold_en,
  output logic          rst_bit
);
  localparam logic [CW-1:0] HIT = CW'(IDX * GAP);

  // Once released a lane stays low until the sequencer leaves RELEASE/RUN.
  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n)               rst_bit <= 1'b1;
    else if (!hold_en)             rst_bit <= 1'b1;
    else if (rel_en && cnt == HIT) rst_bit <= 1'b0;
  end
endmodule

module pll_reset_sequencer #(
  parameter int CLKOUT_NUM     = 6,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_STABLE    = 64,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int RELEASE_GAP    = 16,
  parameter int MAX_RETRY      = 0,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_in_n,
  input  logic                  pll_locked_in,
  input  logic                  pwrdwn_req,
  output logic                  pll_reset_out,
  output logic                  pll_pwrdwn_out,
  output logic [CLKOUT_NUM-1:0] reset_out,
  output logic                  all_ready,
  output logic                  fail,
  output logic [7:0]            retry_cnt,
  output logic [2:0]            state_out
);
  localparam int REL_LAST = (CLKOUT_NUM - 1) * RELEASE_GAP;
  localparam int MAX_AB   = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int MAX_CD   = (PLL_RST_CYCLES > REL_LAST) ? PLL_RST_CYCLES : REL_LAST;
  localparam int MAXV     = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW       = $clog2(MAXV) + 1;

  localparam logic [CW-1:0] RST_END = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_END  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_END = CW'(LOCK_STABLE);
  localparam logic [CW-1:0] REL_END = CW'(REL_LAST);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_PWRDN   = 3'd0,
    S_PLL_RST = 3'd1,
    S_WAIT    = 3'd2,
    S_STABLE  = 3'd3,
    S_RELEASE = 3'd4,
    S_RUN     = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  state_t                 state, nxt;
  logic [CW-1:0]          cnt, cnt_d;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   lk;
  logic                   retry;
  logic [7:0]             retry_nxt, retry_d;
  logic                   prst_d, pwrdn_d, ready_d, fail_d;
  logic                   rel_en, hold_en;

  assign lk        = sync_pipe[SYNC_STAGES-1];
  assign retry_nxt = (retry_cnt == 8'hFF) ? 8'hFF : retry_cnt + 8'd1;
  assign state_out = state;

  // One shared counter: reset pulse width, lock timeout, stable run and release spacing.
  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state          <= S_PLL_RST;
      cnt            <= '0;
      sync_pipe      <= '0;
      pll_reset_out  <= 1'b1;
      pll_pwrdwn_out <= 1'b0;
      all_ready      <= 1'b0;
      fail           <= 1'b0;
      retry_cnt      <= 8'd0;
    end else begin
      state          <= nxt;
      cnt            <= cnt_d;
      sync_pipe      <= {sync_pipe[SYNC_STAGES-2:0], pll_locked_in};
      pll_reset_out  <= prst_d;
      pll_pwrdwn_out <= pwrdn_d;
      all_ready      <= ready_d;
      fail           <= fail_d;
      retry_cnt      <= retry_d;
    end
  end

  always_comb begin
    nxt   = state;
    cnt_d = cnt;
    retry = 1'b0;
    if (pwrdwn_req) begin
      nxt   = S_PWRDN;
      cnt_d = '0;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == RST_END) begin
            nxt   = S_WAIT;
            cnt_d = '0;
          end else cnt_d = cnt + ONE;
        end
        S_WAIT: begin
          if (lk) begin
            nxt   = S_STABLE;
            cnt_d = ONE;
          end else if (cnt == TO_END) retry = 1'b1;
          else cnt_d = cnt + ONE;
        end
        S_STABLE: begin
          // A dropout here only restarts the wait; it does not count as a retry.
          if (!lk) begin
            nxt   = S_WAIT;
            cnt_d = '0;
          end else if (cnt == STB_END) begin
            nxt   = S_RELEASE;
            cnt_d = '0;
          end else cnt_d = cnt + ONE;
        end
        S_RELEASE: begin
          if (!lk) retry = 1'b1;
          else if (cnt == REL_END) begin
            nxt   = S_RUN;
            cnt_d = '0;
          end else cnt_d = cnt + ONE;
        end
        S_RUN:   if (!lk) retry = 1'b1;
        S_FAIL:  nxt = S_FAIL;
        S_PWRDN: begin
          nxt   = S_PLL_RST;
          cnt_d = '0;
        end
        default: begin
          nxt   = S_PLL_RST;
          cnt_d = '0;
        end
      endcase
      if (retry) begin
        cnt_d = '0;
        if ((MAX_RETRY != 0) && (int'({24'd0, retry_nxt}) >= MAX_RETRY)) nxt = S_FAIL;
        else nxt = S_PLL_RST;
      end
    end
  end

  always_comb begin
    prst_d  = (nxt == S_PLL_RST) || (nxt == S_FAIL) || (nxt == S_PWRDN);
    pwrdn_d = (nxt == S_PWRDN);
    ready_d = (nxt == S_RUN);
    fail_d  = (nxt == S_FAIL);
    retry_d = retry ? retry_nxt : retry_cnt;
    rel_en  = (state == S_RELEASE);
    hold_en = ((state == S_RELEASE) || (state == S_RUN)) &&
              ((nxt == S_RELEASE) || (nxt == S_RUN));
  end

  for (genvar i = 0; i < CLKOUT_NUM; i++) begin : g_lane
    pll_rst_lane #(.IDX(i), .GAP(RELEASE_GAP), .CW(CW)) u_lane (
      .clk_in     (clk_in),
      .reset_in_n (reset_in_n),
      .cnt        (cnt),
      .rel_en     (rel_en),
      .hold_en    (hold_en),
      .rst_bit    (reset_out[i])
    );
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised bench for pll_reset_sequencer against a timestamp-based model of the
// sequencing rules, plus directed checks of the key latencies and corner cases.

module tb_pll_reset_sequencer;
  localparam int N = 3, P = 4, LS = 8, TO = 100, GAP = 5, MR = 2, S = 2;
  localparam logic [17:0] RESET_VEC = {3'd1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd0};

  logic clk_in = 1'b0;
  logic reset_in_n, pll_locked_in, pwrdwn_req;
  logic pll_reset_out, pll_pwrdwn_out, all_ready, fail;
  logic [N-1:0] reset_out;
  logic [7:0] retry_cnt;
  logic [2:0] state_out;
  logic [17:0] dut_vec;

  int n_chk = 0, n_pass = 0;

  always #5 clk_in = ~clk_in;

  pll_reset_sequencer #(
    .CLKOUT_NUM(N), .PLL_RST_CYCLES(P), .LOCK_STABLE(LS), .LOCK_TIMEOUT(TO),
    .RELEASE_GAP(GAP), .MAX_RETRY(MR), .SYNC_STAGES(S)
  ) dut (
    .clk_in(clk_in), .reset_in_n(reset_in_n), .pll_locked_in(pll_locked_in),
    .pwrdwn_req(pwrdwn_req), .pll_reset_out(pll_reset_out), .pll_pwrdwn_out(pll_pwrdwn_out),
    .reset_out(reset_out), .all_ready(all_ready), .fail(fail), .retry_cnt(retry_cnt),
    .state_out(state_out)
  );

  assign dut_vec = {state_out, pll_reset_out, pll_pwrdwn_out, reset_out, all_ready, fail, retry_cnt};

  // Model: current mode, the edge it was entered on, and the lock samples in flight.
  typedef enum int {M_PWRDN = 0, M_RST = 1, M_WAIT = 2, M_STABLE = 3,
                    M_RELEASE = 4, M_RUN = 5, M_FAIL = 6} mode_t;
  mode_t m_mode;
  int    m_enter, m_retry, cyc;
  bit    lkq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_mode = M_RST; m_enter = 0; m_retry = 0; cyc = 0;
    lkq.delete();
    for (int i = 0; i < S; i++) lkq.push_back(1'b0);
  endtask

  task automatic go(input mode_t m);
    m_mode = m; m_enter = cyc;
  endtask

  task automatic retry_m();
    m_retry = (m_retry < 255) ? m_retry + 1 : 255;
    if (MR != 0 && m_retry >= MR) go(M_FAIL);
    else go(M_RST);
  endtask

  task automatic model_edge(input bit lock, input bit pwr);
    bit lk;
    int n;
    cyc++;
    lk = lkq.pop_front();
    lkq.push_back(lock);
    n = cyc - m_enter;
    if (pwr) begin
      if (m_mode != M_PWRDN) go(M_PWRDN);
    end else begin
      case (m_mode)
        M_RST:     if (n == P) go(M_WAIT);
        M_WAIT:    if (lk) go(M_STABLE); else if (n == TO) retry_m();
        M_STABLE:  if (!lk) go(M_WAIT); else if (n == LS) go(M_RELEASE);
        M_RELEASE: if (!lk) retry_m(); else if (n == 1 + (N - 1) * GAP) go(M_RUN);
        M_RUN:     if (!lk) retry_m();
        M_PWRDN:   go(M_RST);
        default:   ;
      endcase
    end
  endtask

  function automatic logic [17:0] exp_vec();
    logic [N-1:0] ro;
    int n;
    n  = cyc - m_enter;
    ro = '1;
    if (m_mode == M_RUN) ro = '0;
    else if (m_mode == M_RELEASE)
      for (int i = 0; i < N; i++) if (n >= 1 + i * GAP) ro[i] = 1'b0;
    return {3'(m_mode), (m_mode == M_RST || m_mode == M_FAIL || m_mode == M_PWRDN),
            (m_mode == M_PWRDN), ro, (m_mode == M_RUN), (m_mode == M_FAIL), 8'(m_retry)};
  endfunction

  task automatic step(input bit lock, input bit pwr);
    pll_locked_in = lock;
    pwrdwn_req    = pwr;
    @(posedge clk_in);
    model_edge(lock, pwr);
    @(negedge clk_in);
    chk("outs", {14'd0, dut_vec}, {14'd0, exp_vec()});
  endtask

  task automatic do_reset();
    reset_in_n = 1'b0; pll_locked_in = 1'b0; pwrdwn_req = 1'b0;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    chk("reset_vals", {14'd0, dut_vec}, {14'd0, RESET_VEC});
    reset_in_n = 1'b1;
  endtask

  task automatic wait_bit(input int idx, input int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      step(1'b1, 1'b0);
      if (reset_out[idx] === 1'b0) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t0, f0, f1, f2, d0, at, hi, left;
    bit lv;

    // Clean bring-up and staggered release
    do_reset();
    repeat (6) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    t0 = cyc;
    wait_bit(0, 40, f0);
    chk("lat0", f0 - t0, S + LS + 1);
    wait_bit(1, 40, f1);
    chk("lat1", f1 - t0, S + LS + 1 + GAP);
    wait_bit(2, 40, f2);
    chk("lat2", f2 - t0, S + LS + 1 + 2 * GAP);
    chk("ready_with_last", all_ready, 1);

    // Lock loss in RUN
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    d0 = cyc;
    at = -1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0);
      if (reset_out === 3'b111) begin
        at = cyc;
        break;
      end
    end
    chk("drop_lat", at - d0, S);
    chk("drop_ready", all_ready, 0);
    chk("drop_retry", retry_cnt, 1);
    for (int k = 0; k < 80 && all_ready !== 1'b1; k++) step(1'b1, 1'b0);
    chk("reseq_ready", all_ready, 1);

    // Lock never arrives: two timeouts then FAIL
    do_reset();
    hi = 0;
    for (int k = 0; k < 2 * (P + TO) - 1; k++) begin
      step(1'b0, 1'b0);
      if (cyc >= TO && pll_reset_out === 1'b1) hi++;
    end
    chk("pulse2_w", hi, P);
    chk("pre_fail_state", state_out, 2);
    step(1'b0, 1'b0);
    chk("fail_state", state_out, 6);
    chk("fail_flag", fail, 1);
    chk("fail_retry", retry_cnt, 2);
    chk("fail_pllrst", pll_reset_out, 1);

    // Power-down out of FAIL, then a normal sequence
    step(1'b0, 1'b1);
    chk("pwrdn_out", pll_pwrdwn_out, 1);
    chk("pwrdn_fail_clr", fail, 0);
    repeat (2) step(1'b0, 1'b1);
    hi = 0;
    for (int k = 0; k < 60 && all_ready !== 1'b1; k++) begin
      step(1'b1, 1'b0);
      if (pll_reset_out === 1'b1) hi++;
    end
    chk("pwr_rst_pulse", hi, P);
    chk("pwr_ready", all_ready, 1);
    chk("retry_kept", retry_cnt, 2);

    // Lock glitch during STABLE
    do_reset();
    repeat (6) step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    t0 = cyc;
    wait_bit(0, 40, f0);
    chk("glitch_lat", f0 - t0, S + LS + 1);
    chk("glitch_retry", retry_cnt, 0);

    // Asynchronous reset mid-RELEASE
    repeat (2) step(1'b1, 1'b0);
    #2 reset_in_n = 1'b0;
    #1 chk("async_rst", {14'd0, dut_vec}, {14'd0, RESET_VEC});
    model_reset();
    @(negedge clk_in);
    reset_in_n = 1'b1;
    pll_locked_in = 1'b0;

    // Random lock runs with occasional power-down
    do_reset();
    lv = 1'b0;
    left = 0;
    for (int k = 0; k < 2500; k++) begin
      if (left == 0) begin
        lv = !lv;
        if (lv) left = int'($urandom_range(1, 60));
        else if ($urandom_range(0, 7) == 0) left = int'($urandom_range(100, 220));
        else left = int'($urandom_range(1, 20));
      end
      left--;
      step(lv, $urandom_range(0, 99) < 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
